// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizing and index-width helper for fifo_wr_arbiter
package fifo_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_e;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search for the first valid requester after last_grant
//   valid_i      requester valid vector
//   last_grant_i index of the previous winner; search starts one above it and wraps
//   winner_o     chosen index (0 when nothing is valid)
//   any_valid_o  high when at least one requester is valid
module rr_picker #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [GW-1:0] last_grant_i,
    output logic [GW-1:0] winner_o,
    output logic          any_valid_o
);
    assign any_valid_o = |valid_i;
    // Scan offsets from farthest to nearest so the nearest valid requester is the one left standing
    always_comb begin
        winner_o = '0;
        for (int k = N; k >= 1; k--)
            if (valid_i[(int'(last_grant_i) + k) % N])
                winner_o = GW'((int'(last_grant_i) + k) % N);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
//   clk, rst_n  clock (FIFO write clock) and asynchronous active-low reset
//   req_valid   per-requester word valid
//   req_data    packed words, requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester accept, only the owner's bit can be high
//   fifo_full   FIFO full flag
//   fifo_w_en   FIFO write enable
//   fifo_wdata  FIFO write data
//   grant_id    current (or most recent) owner
//   busy        high while a grant is held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy
);
    localparam int GW = idx_width(NUM_REQ);
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [3:0]    beat_q, beat_d;
    logic [GW-1:0] winner;
    logic          any_valid;
    logic          owner_valid;
    rr_picker #(.N(NUM_REQ), .GW(GW)) u_pick (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .winner_o     (winner),
        .any_valid_o  (any_valid)
    );
    assign owner_valid = req_valid[grant_q];
    assign grant_id    = grant_q;
    assign busy        = state_q == GRANT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_d     = beat_q;
        req_ready  = '0;
        fifo_w_en  = 1'b0;
        fifo_wdata = '0;
        if (state_q == IDLE) begin
            // The arbitration cycle itself never transfers; the winner starts writing next cycle
            if (any_valid) begin
                state_d = GRANT;
                grant_d = winner;
                last_d  = winner;
                beat_d  = '0;
            end
        end else begin
            req_ready[grant_q] = !fifo_full;
            fifo_w_en          = owner_valid & !fifo_full;
            fifo_wdata         = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            // A dropped owner releases even while full; a full FIFO with a valid owner just stalls
            if (!owner_valid)
                state_d = IDLE;
            else if (fifo_w_en) begin
                beat_d = beat_q + 4'd1;
                if (beat_q == LAST_BEAT)
                    state_d = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of two arbiters (MAX_BURST 4 and 1) against a behavioural model
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  va, vb, rdy_a, rdy_b;
    logic        fa, fb, wen_a, wen_b, busy_a, busy_b;
    logic [31:0] da, db;
    logic [7:0]  wd_a, wd_b;
    logic [1:0]  g_a, g_b;
    int checks = 0;
    int failures = 0;
    int own[2], gid[2], lst[2], bts[2], wr[2];
    int mb[2] = '{4, 1};
    int order2[5] = '{0, 1, 2, 3, 0};
    int order6[4] = '{1, 2, 1, 2};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va), .req_data(da), .req_ready(rdy_a),
        .fifo_full(fa), .fifo_w_en(wen_a), .fifo_wdata(wd_a), .grant_id(g_a), .busy(busy_a)
    );
    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_data(db), .req_ready(rdy_b),
        .fifo_full(fb), .fifo_w_en(wen_b), .fifo_wdata(wd_b), .grant_id(g_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, u, obs, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            own[u] = -1; gid[u] = 0; lst[u] = 3; bts[u] = 0;
        end
    endtask

    task automatic upd(input int u, input logic [3:0] v, input logic f);
        int w;
        if (own[u] < 0) begin
            w = rr(v, lst[u]);
            if (w >= 0) begin
                own[u] = w; gid[u] = w; lst[u] = w; bts[u] = 0;
            end
        end else if (!v[own[u]])
            own[u] = -1;
        else if (!f) begin
            bts[u]++;
            if (bts[u] == mb[u]) own[u] = -1;
        end
    endtask

    task automatic exp_chk(input int u, input logic [3:0] v, input logic f, input logic [31:0] d,
                           input logic [3:0] rdy, input logic we, input logic [7:0] wd,
                           input logic [1:0] g, input logic b);
        logic [3:0] er;
        logic       ew;
        logic [7:0] ed;
        int o;
        o = own[u]; er = '0; ew = 1'b0; ed = '0;
        if (o >= 0) begin
            if (!f) er[o] = 1'b1;
            ew = v[o] & !f;
            ed = d[o*8 +: 8];
        end
        chk("busy", u, 32'(b), 32'(o >= 0));
        chk("req_ready", u, 32'(rdy), 32'(er));
        chk("fifo_w_en", u, 32'(we), 32'(ew));
        chk("fifo_wdata", u, 32'(wd), 32'(ed));
        chk("grant_id", u, 32'(g), gid[u]);
    endtask

    task automatic tick();
        @(negedge clk);
        exp_chk(0, va, fa, da, rdy_a, wen_a, wd_a, g_a, busy_a);
        exp_chk(1, vb, fb, db, rdy_b, wen_b, wd_b, g_b, busy_b);
        if (wen_a === 1'b1) wr[0]++;
        if (wen_b === 1'b1) wr[1]++;
        @(posedge clk);
        if (rst_n) begin
            upd(0, va, fa);
            upd(1, vb, fb);
        end
        #1;
    endtask

    // Pulse reset between clock edges and require every output to drop at once
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 0, 32'(busy_a), 0);
        chk("rst_ready", 0, 32'(rdy_a), 0);
        chk("rst_w_en", 0, 32'(wen_a), 0);
        chk("rst_wdata", 0, 32'(wd_a), 0);
        chk("rst_grant", 0, 32'(g_a), 0);
        chk("rst_busy", 1, 32'(busy_b), 0);
        chk("rst_w_en", 1, 32'(wen_b), 0);
        chk("rst_grant", 1, 32'(g_b), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        va = '0; vb = '0; fa = 1'b0; fb = 1'b0; da = '0; db = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // Sole requester 0: 1-cycle arbitration, 4 writes, 1 idle, regrant
        da = 32'hD3C2B1A0; va = 4'b0001; wr[0] = 0;
        tick();
        chk("s1_busy", 0, 32'(busy_a), 1);
        chk("s1_grant", 0, 32'(g_a), 0);
        repeat (5) tick();
        chk("s1_writes", 0, wr[0], 4);
        chk("s1_regrant", 0, 32'(busy_a), 1);
        // All valid: rotation 0,1,2,3,0
        do_reset();
        da = 32'h44332211; va = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s2_order", 0, 32'(g_a), order2[k]);
            repeat (4) tick();
        end
        // Owner 2 stalled by a full FIFO after 2 beats
        do_reset();
        da = 32'h5A4B3C2D; va = 4'b0100; wr[0] = 0;
        repeat (3) tick();
        fa = 1'b1;
        repeat (3) tick();
        chk("s3_hold", 0, 32'(g_a), 2);
        fa = 1'b0;
        repeat (2) tick();
        chk("s3_writes", 0, wr[0], 4);
        chk("s3_idle", 0, 32'(busy_a), 0);
        // Owner 1 drops after 2 beats; next grant goes to 3
        do_reset();
        va = 4'b1010;
        repeat (3) tick();
        va = 4'b1000;
        tick();
        chk("s4_idle", 0, 32'(busy_a), 0);
        tick();
        chk("s4_next", 0, 32'(g_a), 3);
        // Reset mid-burst at beat 1, then requester 0 wins first
        do_reset();
        va = 4'b0001;
        repeat (2) tick();
        do_reset();
        va = 4'b1111;
        tick();
        chk("s5_first", 0, 32'(g_a), 0);
        // MAX_BURST=1 alternates 1,2,1,2 with one beat each
        va = '0; vb = 4'b0110; db = 32'h9988_7766; wr[1] = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s6_order", 1, 32'(g_b), order6[k]);
            tick();
        end
        chk("s6_writes", 1, wr[1], 4);
        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            va = 4'($urandom); vb = 4'($urandom);
            fa = $urandom_range(0, 3) == 0; fb = $urandom_range(0, 3) == 0;
            da = $urandom; db = $urandom;
            if ($urandom_range(0, 99) == 0) do_reset();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
